// File: rtl/dmem_access_unit_if.sv
// ---------------------------------------------------------------------------
// dmem_access_unit_if
//   Data-bus handshake between dmem_access_unit (master) and the memory
//   system (slave).
//
//   bus_valid  master->slave  request valid, held until bus_ready
//   bus_we     master->slave  1 = write, 0 = read
//   bus_be     master->slave  byte enables
//   bus_addr   master->slave  word-aligned byte address
//   bus_wdata  master->slave  write data
//   bus_ready  slave->master  request accepted while bus_valid is high
//   bus_rvalid slave->master  read data valid
//   bus_rdata  slave->master  read data
// ---------------------------------------------------------------------------
interface dmem_access_unit_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    localparam int BE_W = DATA_W / 8;

    logic              bus_valid;
    logic              bus_we;
    logic [BE_W-1:0]   bus_be;
    logic [ADDR_W-1:0] bus_addr;
    logic [DATA_W-1:0] bus_wdata;
    logic              bus_ready;
    logic              bus_rvalid;
    logic [DATA_W-1:0] bus_rdata;

    modport master (
        output bus_valid, bus_we, bus_be, bus_addr, bus_wdata,
        input  bus_ready, bus_rvalid, bus_rdata
    );

    modport slave (
        input  bus_valid, bus_we, bus_be, bus_addr, bus_wdata,
        output bus_ready, bus_rvalid, bus_rdata
    );
endinterface

// File: rtl/dmem_access_unit.sv
// ---------------------------------------------------------------------------
// dmem_access_unit
//   Data-memory access unit between the memory stage and the data bus.
//   Stores are posted into a WBUF_DEPTH-entry circular write buffer and
//   drained in order; loads run one at a time and return a registered,
//   lane-masked response.
//
//   Optional feature macro: DMEM_LOAD_FWD_EN -- when defined, a load whose
//   bytes are fully covered by the youngest matching buffered store is
//   answered from the buffer without a bus access.
//
//   Ports:
//     cpu_clk_50M, cpu_rst_n   clock / async active-low reset
//     req_*                    memory-stage request (valid/ready)
//     flush                    pipeline flush, cancels a pending load response
//     rsp_valid, rsp_rdata     registered load response
//     stall_o                  req_valid & ~req_ready
//     bus                      data-bus master port (dmem_access_unit_if)
//     wbuf_count, wbuf_empty   write-buffer occupancy
// ---------------------------------------------------------------------------
module dmem_access_unit #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int WBUF_DEPTH = 4
) (
    input  logic                              cpu_clk_50M,
    input  logic                              cpu_rst_n,
    input  logic                              req_valid,
    input  logic                              req_we,
    input  logic [DATA_W/8-1:0]               req_be,
    input  logic [ADDR_W-1:0]                 req_addr,
    input  logic [DATA_W-1:0]                 req_wdata,
    output logic                              req_ready,
    input  logic                              flush,
    output logic                              rsp_valid,
    output logic [DATA_W-1:0]                 rsp_rdata,
    output logic                              stall_o,
    dmem_access_unit_if.master                bus,
    output logic [$clog2(WBUF_DEPTH+1)-1:0]   wbuf_count,
    output logic                              wbuf_empty
);
    localparam int BE_W  = DATA_W / 8;
    localparam int PTR_W = $clog2(WBUF_DEPTH);
    localparam int CNT_W = $clog2(WBUF_DEPTH + 1);

    typedef enum logic [1:0] {IDLE, WR_REQ, RD_REQ, RD_WAIT} state_t;

    function automatic logic [ADDR_W-1:0] word_of(input logic [ADDR_W-1:0] a);
        return a & ~ADDR_W'(BE_W - 1);
    endfunction

    function automatic logic [DATA_W-1:0] lane_mask(input logic [BE_W-1:0] be);
        logic [DATA_W-1:0] m;
        m = '0;
        for (int i = 0; i < BE_W; i++) m[8*i +: 8] = {8{be[i]}};
        return m;
    endfunction

    state_t            state;
    logic [PTR_W-1:0]  head, tail;
    logic [CNT_W-1:0]  count;
    logic [ADDR_W-1:0] rd_addr;
    logic [BE_W-1:0]   rd_be;
    logic              load_flushed;

    // NOTE: buffer storage has no reset; an entry is only meaningful while
    // count says it is occupied, so resetting it would buy nothing.
    logic [ADDR_W-1:0] wb_addr [WBUF_DEPTH];
    logic [BE_W-1:0]   wb_be   [WBUF_DEPTH];
    logic [DATA_W-1:0] wb_data [WBUF_DEPTH];

    logic fwd_hit;
`ifdef DMEM_LOAD_FWD_EN
    logic [DATA_W-1:0] fwd_data;

    // Walk oldest to youngest so the last match seen is the youngest one.
    always_comb begin
        logic [PTR_W-1:0] idx;
        logic             found;
        logic [BE_W-1:0]  found_be;
        // NOTE: every combinational output gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        found    = 1'b0;
        found_be = '0;
        fwd_data = '0;
        idx      = '0;
        for (int i = 0; i < WBUF_DEPTH; i++) begin
            idx = head + PTR_W'(i);
            if (CNT_W'(i) < count && wb_addr[idx] == word_of(req_addr)) begin
                found    = 1'b1;
                found_be = wb_be[idx];
                fwd_data = wb_data[idx];
            end
        end
        fwd_hit = found && ((found_be & req_be) == req_be);
    end
`else
    assign fwd_hit = 1'b0;
`endif

    // Acceptance looks only at registered state, flush and the request itself.
    // A full buffer refuses a store even if the head retires this cycle.
    logic can_store, can_load, push, pop, load_acc;
    assign can_store  = ~flush & (count < CNT_W'(WBUF_DEPTH));
    assign can_load   = ~flush & (state == IDLE) & ((count == '0) | fwd_hit);
    assign req_ready  = req_we ? can_store : can_load;
    assign stall_o    = req_valid & ~req_ready;
    assign push       = req_valid & req_ready & req_we;
    assign load_acc   = req_valid & req_ready & ~req_we;
    assign pop        = (state == WR_REQ) & bus.bus_ready;
    assign wbuf_count = count;
    assign wbuf_empty = (count == '0);

    always_ff @(posedge cpu_clk_50M) begin
        if (push) begin
            wb_addr[tail] <= word_of(req_addr);
            wb_be[tail]   <= req_be;
            wb_data[tail] <= req_wdata;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            state        <= IDLE;
            head         <= '0;
            tail         <= '0;
            count        <= '0;
            rd_addr      <= '0;
            rd_be        <= '0;
            load_flushed <= 1'b0;
            rsp_valid    <= 1'b0;
            rsp_rdata    <= '0;
        end else begin
            rsp_valid <= 1'b0;
            if (push) tail <= tail + PTR_W'(1);
            if (pop)  head <= head + PTR_W'(1);
            if (push && !pop)      count <= count + CNT_W'(1);
            else if (pop && !push) count <= count - CNT_W'(1);

            // Remember any flush seen while a load is pending; a new load
            // can only be accepted with flush low, which clears it.
            if (flush) load_flushed <= 1'b1;

            case (state)
                IDLE: begin
                    if (count != '0) begin
                        state <= WR_REQ;
`ifdef DMEM_LOAD_FWD_EN
                        if (load_acc) begin
                            rsp_valid <= 1'b1;
                            rsp_rdata <= fwd_data & lane_mask(req_be);
                        end
`endif
                    end else if (load_acc) begin
                        rd_addr      <= word_of(req_addr);
                        rd_be        <= req_be;
                        load_flushed <= 1'b0;
                        state        <= RD_REQ;
                    end
                end
                WR_REQ:  if (bus.bus_ready) state <= IDLE;
                RD_REQ:  if (bus.bus_ready) state <= RD_WAIT;
                RD_WAIT: begin
                    if (bus.bus_rvalid) begin
                        rsp_rdata <= bus.bus_rdata & lane_mask(rd_be);
                        rsp_valid <= ~(load_flushed | flush);
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Bus outputs follow state and registered sources only, so they hold
    // steady while the slave stalls.
    always_comb begin
        bus.bus_valid = 1'b0;
        bus.bus_we    = 1'b0;
        bus.bus_be    = '0;
        bus.bus_addr  = '0;
        bus.bus_wdata = '0;
        case (state)
            WR_REQ: begin
                bus.bus_valid = 1'b1;
                bus.bus_we    = 1'b1;
                bus.bus_be    = wb_be[head];
                bus.bus_addr  = wb_addr[head];
                bus.bus_wdata = wb_data[head];
            end
            RD_REQ: begin
                bus.bus_valid = 1'b1;
                bus.bus_be    = rd_be;
                bus.bus_addr  = rd_addr;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_dmem_access_unit.sv
// ---------------------------------------------------------------------------
// tb_dmem_access_unit
//   Directed bench for dmem_access_unit (32-bit address/data, 4-entry write
//   buffer). Inputs change 1 ns after the rising edge; outputs are observed
//   1 ns later. Bus handshakes are logged on the falling edge.
// ---------------------------------------------------------------------------
module tb_dmem_access_unit;
    logic        clk;
    logic        rst_n;
    logic        req_valid, req_we, req_ready, flush;
    logic [3:0]  req_be;
    logic [31:0] req_addr, req_wdata;
    logic        rsp_valid, stall_o, wbuf_empty;
    logic [31:0] rsp_rdata;
    logic [2:0]  wbuf_count;

    dmem_access_unit_if #(.ADDR_W(32), .DATA_W(32)) bus_if ();

    dmem_access_unit #(.ADDR_W(32), .DATA_W(32), .WBUF_DEPTH(4)) dut (
        .cpu_clk_50M (clk),
        .cpu_rst_n   (rst_n),
        .req_valid   (req_valid),
        .req_we      (req_we),
        .req_be      (req_be),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .req_ready   (req_ready),
        .flush       (flush),
        .rsp_valid   (rsp_valid),
        .rsp_rdata   (rsp_rdata),
        .stall_o     (stall_o),
        .bus         (bus_if),
        .wbuf_count  (wbuf_count),
        .wbuf_empty  (wbuf_empty)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    int tests  = 0;
    int errors = 0;
    logic [31:0] wlog_addr[$];
    logic [31:0] wlog_data[$];
    int rd_cnt = 0;

    always @(negedge clk) begin
        if (rst_n && bus_if.bus_valid && bus_if.bus_ready) begin
            if (bus_if.bus_we) begin
                wlog_addr.push_back(bus_if.bus_addr);
                wlog_data.push_back(bus_if.bus_wdata);
            end else begin
                rd_cnt++;
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_req();
        req_valid = 1'b0; req_we = 1'b0; req_be = 4'h0;
        req_addr = 32'h0; req_wdata = 32'h0;
    endtask

    task automatic set_req(input logic we, input logic [3:0] be,
                           input logic [31:0] addr, input logic [31:0] wdata);
        req_valid = 1'b1; req_we = we; req_be = be;
        req_addr = addr; req_wdata = wdata;
    endtask

    task automatic drain(input string tag);
        logic ok;
        ok = 1'b0;
        bus_if.bus_ready = 1'b1;
        #1;
        for (int c = 0; c < 60 && !ok; c++) begin
            if (wbuf_empty && !bus_if.bus_valid) ok = 1'b1;
            else step();
        end
        check({tag, "_drain"}, ok, 1);
        bus_if.bus_ready = 1'b0;
    endtask

    initial begin
        logic done, acc, got;
        int rd0;

        rst_n = 1'b0; flush = 1'b0; idle_req();
        bus_if.bus_ready = 1'b0; bus_if.bus_rvalid = 1'b0; bus_if.bus_rdata = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        step();

        // ---- reset in the middle of RD_REQ ----
        set_req(1'b0, 4'hF, 32'h40, 32'h0); #1;
        check("t1_load_ready", req_ready, 1);
        step(); idle_req(); #1;
        check("t1_rd_req_valid", bus_if.bus_valid, 1);
        check("t1_rd_req_addr", bus_if.bus_addr, 32'h40);
        rst_n = 1'b0; #1;
        check("t1_rst_bus_valid", bus_if.bus_valid, 0);
        check("t1_rst_bus_addr", bus_if.bus_addr, 0);
        check("t1_rst_bus_be", bus_if.bus_be, 0);
        check("t1_rst_rsp_valid", rsp_valid, 0);
        check("t1_rst_rsp_rdata", rsp_rdata, 0);
        check("t1_rst_count", wbuf_count, 0);
        check("t1_rst_empty", wbuf_empty, 1);
        step(); rst_n = 1'b1; step();
        set_req(1'b0, 4'hF, 32'h40, 32'h0); #1;
        check("t1_post_rst_load_ready", req_ready, 1);
        check("t1_post_rst_bus_valid", bus_if.bus_valid, 0);
        idle_req();

        // ---- five stores into a stalled bus, then drain ----
        wlog_addr.delete(); wlog_data.delete();
        for (int i = 0; i < 4; i++) begin
            set_req(1'b1, 4'hF, 32'h100 + 32'(4*i), 32'hA000_0000 + 32'(i)); #1;
            check($sformatf("t2_st%0d_ready", i), req_ready, 1);
            step();
            if (i == 0) check("t2_bv_cycle_t1", bus_if.bus_valid, 0);
            if (i == 1) begin
                check("t2_bv_cycle_t2", bus_if.bus_valid, 1);
                check("t2_bv_we", bus_if.bus_we, 1);
                check("t2_bv_addr", bus_if.bus_addr, 32'h100);
            end
        end
        set_req(1'b1, 4'hF, 32'h110, 32'hA000_0004); #1;
        check("t2_full_stall", stall_o, 1);
        check("t2_full_count", wbuf_count, 4);
        step();
        check("t2_refused_count", wbuf_count, 4);
        bus_if.bus_ready = 1'b1; #1;
        check("t2_no_bypass", req_ready, 0);
        done = 1'b0;
        for (int c = 0; c < 50 && !done; c++) begin
            acc = req_valid && req_ready;
            step();
            if (acc) req_valid = 1'b0;
            #1;
            if (!req_valid && wbuf_empty && !bus_if.bus_valid) done = 1'b1;
        end
        check("t2_drain_done", done, 1);
        bus_if.bus_ready = 1'b0;
        check("t2_nwrites", wlog_addr.size(), 5);
        for (int i = 0; i < wlog_addr.size(); i++) begin
            check($sformatf("t2_waddr%0d", i), wlog_addr[i], 32'h100 + 32'(4*i));
            check($sformatf("t2_wdata%0d", i), wlog_data[i], 32'hA000_0000 + 32'(i));
        end
        idle_req();

        // ---- zero-wait load, lanes [15:0] ----
        bus_if.bus_ready = 1'b1;
        set_req(1'b0, 4'b0011, 32'h200, 32'h0); #1;
        check("t3_ready", req_ready, 1);
        step(); idle_req(); #1;
        check("t3_rd_valid", bus_if.bus_valid, 1);
        check("t3_rd_we", bus_if.bus_we, 0);
        check("t3_rd_addr", bus_if.bus_addr, 32'h200);
        check("t3_rd_be", bus_if.bus_be, 4'b0011);
        step(); bus_if.bus_rvalid = 1'b1; bus_if.bus_rdata = 32'hDEAD_BEEF; #1;
        check("t3_rsp_not_yet", rsp_valid, 0);
        step(); bus_if.bus_rvalid = 1'b0; bus_if.bus_rdata = '0; #1;
        check("t3_rsp_valid", rsp_valid, 1);
        check("t3_rsp_rdata", rsp_rdata, 32'h0000_BEEF);
        step();
        check("t3_rsp_pulse", rsp_valid, 0);

        // ---- unaligned load, stalled bus, stray rvalid in RD_REQ ----
        bus_if.bus_ready = 1'b0;
        set_req(1'b0, 4'b1100, 32'h20E, 32'h0); #1;
        step(); idle_req(); #1;
        check("t3b_addr_aligned", bus_if.bus_addr, 32'h20C);
        check("t3b_be", bus_if.bus_be, 4'b1100);
        step();
        bus_if.bus_rvalid = 1'b1; bus_if.bus_rdata = 32'h1234_5678; bus_if.bus_ready = 1'b1; #1;
        check("t3b_stall_valid", bus_if.bus_valid, 1);
        check("t3b_stall_addr", bus_if.bus_addr, 32'h20C);
        step(); bus_if.bus_rvalid = 1'b0; bus_if.bus_rdata = '0; #1;
        check("t3b_stray_rvalid_ignored", rsp_valid, 0);
        step(); bus_if.bus_rvalid = 1'b1; bus_if.bus_rdata = 32'hDEAD_BEEF;
        step(); bus_if.bus_rvalid = 1'b0; bus_if.bus_rdata = '0; #1;
        check("t3b_rsp_valid", rsp_valid, 1);
        check("t3b_rsp_rdata", rsp_rdata, 32'hDEAD_0000);

        // ---- store then load of the same word ----
        wlog_addr.delete(); wlog_data.delete();
        rd0 = rd_cnt;
        bus_if.bus_ready = 1'b0;
        set_req(1'b1, 4'hF, 32'h300, 32'hCAFE_F00D); #1;
        check("t4_store_ready", req_ready, 1);
        step();
        set_req(1'b0, 4'hF, 32'h300, 32'h0); #1;
`ifdef DMEM_LOAD_FWD_EN
        check("t4_fwd_ready", req_ready, 1);
        step(); idle_req(); #1;
        check("t4_fwd_rsp_valid", rsp_valid, 1);
        check("t4_fwd_rsp_rdata", rsp_rdata, 32'hCAFE_F00D);
        drain("t4");
        check("t4_fwd_no_bus_read", rd_cnt - rd0, 0);
        check("t4_fwd_write_done", wlog_addr.size(), 1);
`else
        check("t4_load_stalls", stall_o, 1);
        bus_if.bus_ready = 1'b1; #1;
        got = 1'b0;
        for (int c = 0; c < 20 && !got; c++) begin
            if (req_ready) got = 1'b1;
            else step();
        end
        check("t4_load_accept", got, 1);
        check("t4_write_first", wlog_addr.size(), 1);
        step(); idle_req(); #1;
        check("t4_rd_valid", bus_if.bus_valid, 1);
        check("t4_rd_we", bus_if.bus_we, 0);
        check("t4_rd_addr", bus_if.bus_addr, 32'h300);
        step(); bus_if.bus_rvalid = 1'b1; bus_if.bus_rdata = 32'hCAFE_F00D;
        step(); bus_if.bus_rvalid = 1'b0; bus_if.bus_rdata = '0; #1;
        check("t4_rsp_valid", rsp_valid, 1);
        check("t4_rsp_rdata", rsp_rdata, 32'hCAFE_F00D);
        check("t4_one_bus_read", rd_cnt - rd0, 1);
`endif
        if (wlog_addr.size() > 0) check("t4_write_addr", wlog_addr[0], 32'h300);
        idle_req();

        // ---- flush while waiting for read data ----
        bus_if.bus_ready = 1'b1;
        set_req(1'b0, 4'hF, 32'h400, 32'h0); #1;
        step(); idle_req();
        step();
        flush = 1'b1; #1;
        check("t5_flush_blocks_load", req_ready, 0);
        step(); flush = 1'b0; bus_if.bus_rvalid = 1'b1; bus_if.bus_rdata = 32'h1111_2222;
        step(); bus_if.bus_rvalid = 1'b0; bus_if.bus_rdata = '0; #1;
        check("t5_rsp_suppressed", rsp_valid, 0);
        check("t5_back_idle", req_ready, 1);
        check("t5_bus_idle", bus_if.bus_valid, 0);
        step();
        check("t5_rsp_still_low", rsp_valid, 0);

        set_req(1'b0, 4'hF, 32'h404, 32'h0); #1;
        step(); idle_req();
        step();
        flush = 1'b1; bus_if.bus_rvalid = 1'b1; bus_if.bus_rdata = 32'h3333_4444;
        step(); flush = 1'b0; bus_if.bus_rvalid = 1'b0; bus_if.bus_rdata = '0; #1;
        check("t5b_same_cycle_suppressed", rsp_valid, 0);
        check("t5b_back_idle", req_ready, 1);

        set_req(1'b0, 4'hF, 32'h408, 32'h0); #1;
        step(); idle_req();
        step(); bus_if.bus_rvalid = 1'b1; bus_if.bus_rdata = 32'h55AA_55AA;
        step(); bus_if.bus_rvalid = 1'b0; bus_if.bus_rdata = '0; #1;
        check("t5c_rsp_after_flush", rsp_valid, 1);
        check("t5c_rdata", rsp_rdata, 32'h55AA_55AA);

        // ---- enqueue on the cycle the head retires ----
        wlog_addr.delete(); wlog_data.delete();
        bus_if.bus_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            set_req(1'b1, 4'hF, 32'h600 + 32'(4*k), 32'hB000_0000 + 32'(k));
            step();
        end
        idle_req(); #1;
        check("t6_in_wr_req", bus_if.bus_valid, 1);
        for (int k = 0; k < 8; k++) begin
            set_req(1'b1, 4'hF, 32'h600 + 32'(4*(k+2)), 32'hB000_0000 + 32'(k+2));
            bus_if.bus_ready = 1'b1; #1;
            check($sformatf("t6_ready%0d", k), req_ready, 1);
            step(); idle_req(); bus_if.bus_ready = 1'b0; #1;
            check($sformatf("t6_count%0d", k), wbuf_count, 2);
            step();
        end
        drain("t6");
        check("t6_nwrites", wlog_addr.size(), 10);
        for (int i = 0; i < wlog_addr.size(); i++) begin
            check($sformatf("t6_waddr%0d", i), wlog_addr[i], 32'h600 + 32'(4*i));
            check($sformatf("t6_wdata%0d", i), wlog_data[i], 32'hB000_0000 + 32'(i));
        end

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end
endmodule
